// File: rtl/nibble_serial_alu_adder.sv
// rtl/nibble_serial_alu_adder.sv - 16-bit add/sub/PADDSB sequencer driving a 4-bit CLA one nibble per cycle
// Optional build macro: SERIAL_ADDER_FLAGS_EN (zero/overflow/negative flag registers)

module nibble_serial_alu_adder #(
    parameter int NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [1:0]             op,
    input  logic [4*NIBBLES-1:0]   a,
    input  logic [4*NIBBLES-1:0]   b,
    output logic [3:0]             cla_a,
    output logic [3:0]             cla_b,
    output logic                   cla_cin,
    output logic                   cla_cntrl,
    input  logic [3:0]             cla_s,
    input  logic                   cla_cout,
    input  logic                   cla_c3,
    output logic                   busy,
    output logic                   done,
    output logic [4*NIBBLES-1:0]   result,
    output logic                   flag_z,
    output logic                   flag_v,
    output logic                   flag_n
);

    localparam int W  = 4 * NIBBLES;
    localparam int CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    localparam logic [1:0] OP_SUB    = 2'b01;
    localparam logic [1:0] OP_PADDSB = 2'b10;

    localparam logic [CW-1:0] CNT_LAST = CW'(NIBBLES - 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic [CW-1:0]   cnt;
    logic [W-1:0]    a_q;
    logic [W-1:0]    b_q;
    logic [1:0]      op_q;
    logic            carry_q;
    logic [W-1:0]    psum;
    logic [W-1:0]    psum_next;
    logic [W-1:0]    sat_result;
    logic [CW+1:0]   nib_base;
    logic            is_sub;
    logic            is_padd;
    logic            last;
    logic            ovf_last;
    logic            accept;

    assign is_sub   = (op_q == OP_SUB);
    assign is_padd  = (op_q == OP_PADDSB);
    assign last     = (state_q == RUN) && (cnt == CNT_LAST);
    assign accept   = (state_q == IDLE) && start;
    assign nib_base = {cnt, 2'b00};
    assign busy     = (state_q == RUN);

    // Signed overflow of the full-width add; PADDSB never saturates at 16 bits
    assign ovf_last = !is_padd && (cla_c3 ^ cla_cout);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: leave IDLE on start, return after the last nibble
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (cnt == CNT_LAST) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Present the current nibble to the CLA; everything idles at zero outside RUN
    always_comb begin
        cla_a     = 4'h0;
        cla_b     = 4'h0;
        cla_cin   = 1'b0;
        cla_cntrl = 1'b0;
        if (state_q == RUN) begin
            cla_a     = a_q[nib_base +: 4];
            cla_b     = b_q[nib_base +: 4] ^ {4{is_sub}};
            cla_cin   = is_padd ? 1'b0 : carry_q;
            cla_cntrl = is_padd;
        end
    end

    // Merge this cycle's CLA nibble into the partial sum and apply 16-bit saturation
    always_comb begin
        psum_next = psum;
        psum_next[nib_base +: 4] = cla_s;
        sat_result = psum_next;
        if (ovf_last) begin
            sat_result = a_q[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
        end
    end

    // Operand capture, nibble counter, carry chain, result and done pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= 2'b00;
            carry_q <= 1'b0;
            psum    <= '0;
            result  <= '0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                a_q     <= a;
                b_q     <= b;
                op_q    <= op;
                cnt     <= '0;
                carry_q <= (op == OP_SUB);
                psum    <= '0;
            end else if (state_q == RUN) begin
                carry_q <= cla_cout;
                psum    <= psum_next;
                if (last) begin
                    cnt    <= '0;
                    result <= sat_result;
                    done   <= 1'b1;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

`ifdef SERIAL_ADDER_FLAGS_EN
    logic flag_z_q;
    logic flag_v_q;
    logic flag_n_q;

    // Flags track the last ADD/SUB completion; PADDSB leaves them untouched
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flag_z_q <= 1'b0;
            flag_v_q <= 1'b0;
            flag_n_q <= 1'b0;
        end else if (last && !is_padd) begin
            flag_z_q <= (sat_result == '0);
            flag_v_q <= ovf_last;
            flag_n_q <= sat_result[W-1];
        end
    end

    assign flag_z = flag_z_q;
    assign flag_v = flag_v_q;
    assign flag_n = flag_n_q;
`else
    assign flag_z = 1'b0;
    assign flag_v = 1'b0;
    assign flag_n = 1'b0;
`endif

endmodule
